// File: rtl/app_launcher_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : app_launcher_ctrl
//  Description : Home-screen launcher. Debounces navigation buttons, moves the
//                icon cursor, and switches the pixel mux between the home
//                screen and the apps on frame boundaries only.
//  Revision    : 1.0 - initial release
// ============================================================================
module app_launcher_ctrl #(
    parameter  int NUM_APPS        = 2,
    parameter  int PIX_PER_FRAME   = 76800,
    parameter  int DEBOUNCE_CYCLES = 250000,
    localparam int CUR_W           = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                framebufferClk,
    input  logic                btn_prev,
    input  logic                btn_next,
    input  logic                btn_select,
    input  logic                btn_home,
    input  logic                app_exit,
    output logic [CUR_W-1:0]    cursor,
    output logic [1:0]          disp_sel,
    output logic [NUM_APPS-1:0] app_run,
    output logic                frame_start,
    output logic                busy
);

    localparam int PIX_W = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PIX_W-1:0] c_PIX_LAST = PIX_W'(PIX_PER_FRAME - 1);
    localparam logic [DB_W-1:0]  c_DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CUR_W-1:0] c_CUR_LAST = CUR_W'(NUM_APPS - 1);

    localparam int c_BTN_PREV   = 0;
    localparam int c_BTN_NEXT   = 1;
    localparam int c_BTN_SELECT = 2;
    localparam int c_BTN_HOME   = 3;

    localparam logic [1:0] c_ST_HOME   = 2'd0;
    localparam logic [1:0] c_ST_LAUNCH = 2'd1;
    localparam logic [1:0] c_ST_RUN    = 2'd2;
    localparam logic [1:0] c_ST_EXIT   = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                r_fbclk_d;
    logic [PIX_W-1:0]    r_pix_cnt;
    logic                r_frame_start;
    logic                w_fb_rise;
    logic                w_pix_wrap;
    logic [3:0]          w_raw;
    logic [3:0]          w_press;
    logic [CUR_W-1:0]    r_cursor;
    logic [CUR_W-1:0]    r_target;
    logic [1:0]          r_disp_sel;
    logic [NUM_APPS-1:0] r_app_run;
    logic [NUM_APPS-1:0] w_onehot;
    logic                w_busy;
    logic                w_nav_en;
    logic                w_load_app;
    logic                w_clear_app;

    // ------------------------------------------------------------------
    // Frame boundary tracking from the pixel strobe
    // ------------------------------------------------------------------
    assign w_fb_rise  = framebufferClk & ~r_fbclk_d;
    assign w_pix_wrap = w_fb_rise && (r_pix_cnt == c_PIX_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fbclk_d     <= 1'b0;
            r_pix_cnt     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_fbclk_d     <= framebufferClk;
            r_frame_start <= w_pix_wrap;
            if (w_fb_rise) begin
                r_pix_cnt <= w_pix_wrap ? '0 : r_pix_cnt + PIX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Button debounce; a press event fires only when the filtered level rises
    // ------------------------------------------------------------------
    assign w_raw = {btn_home, btn_select, btn_next, btn_prev};

    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
        logic [DB_W-1:0] r_cnt;
        logic            r_filt;
        logic            r_press;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt   <= '0;
                r_filt  <= 1'b0;
                r_press <= 1'b0;
            end else begin
                r_press <= 1'b0;
                if (w_raw[gi] == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_cnt   <= '0;
                    r_filt  <= w_raw[gi];
                    r_press <= w_raw[gi];
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    // ------------------------------------------------------------------
    // Launcher FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_HOME;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A frame_start seen in HOME or RUN is ignored, so the switch always
    // waits for a boundary strictly after the launch/exit request.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_HOME:   if (w_press[c_BTN_SELECT]) w_state_next = c_ST_LAUNCH;
            c_ST_LAUNCH: if (r_frame_start)         w_state_next = c_ST_RUN;
            c_ST_RUN:    if (w_press[c_BTN_HOME] || app_exit) w_state_next = c_ST_EXIT;
            c_ST_EXIT:   if (r_frame_start)         w_state_next = c_ST_HOME;
            default:                                w_state_next = c_ST_HOME;
        endcase
    end

    always_comb begin
        w_busy      = 1'b0;
        w_nav_en    = 1'b0;
        w_load_app  = 1'b0;
        w_clear_app = 1'b0;
        case (r_state)
            c_ST_HOME: begin
                w_nav_en = 1'b1;
            end
            c_ST_LAUNCH: begin
                w_busy     = 1'b1;
                w_load_app = r_frame_start;
            end
            c_ST_EXIT: begin
                w_busy      = 1'b1;
                w_clear_app = r_frame_start;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Cursor, launch target and display/run registers
    // ------------------------------------------------------------------
    assign w_onehot = NUM_APPS'(1) << r_target;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cursor   <= '0;
            r_target   <= '0;
            r_disp_sel <= 2'd0;
            r_app_run  <= '0;
        end else begin
            if (w_nav_en) begin
                if (w_press[c_BTN_SELECT]) begin
                    r_target <= r_cursor;
                end else if (w_press[c_BTN_NEXT] && !w_press[c_BTN_PREV]) begin
                    r_cursor <= (r_cursor == c_CUR_LAST) ? '0 : r_cursor + CUR_W'(1);
                end else if (w_press[c_BTN_PREV] && !w_press[c_BTN_NEXT]) begin
                    r_cursor <= (r_cursor == '0) ? c_CUR_LAST : r_cursor - CUR_W'(1);
                end
            end
            if (w_load_app) begin
                r_disp_sel <= 2'(r_target) + 2'd1;
                r_app_run  <= w_onehot;
            end else if (w_clear_app) begin
                r_disp_sel <= 2'd0;
                r_app_run  <= '0;
            end
        end
    end

    assign cursor      = r_cursor;
    assign disp_sel    = r_disp_sel;
    assign app_run     = r_app_run;
    assign frame_start = r_frame_start;
    assign busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_app_launcher_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_app_launcher_ctrl
//  Description : Scoreboard bench for app_launcher_ctrl with short frames and
//                a short debounce window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_app_launcher_ctrl;

    localparam int c_PPF = 16;

    logic       clk            = 1'b0;
    logic       reset_n        = 1'b0;
    logic       framebufferClk = 1'b0;
    logic       btn_prev       = 1'b0;
    logic       btn_next       = 1'b0;
    logic       btn_select     = 1'b0;
    logic       btn_home       = 1'b0;
    logic       app_exit       = 1'b0;
    logic       cursor;
    logic [1:0] disp_sel;
    logic [1:0] app_run;
    logic       frame_start;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int fb_edges = 0;

    // Scoreboard entries are {cursor, disp_sel, app_run}
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];
    logic [4:0] mon_last = 5'd0;

    app_launcher_ctrl #(
        .NUM_APPS        (2),
        .PIX_PER_FRAME   (c_PPF),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .framebufferClk (framebufferClk),
        .btn_prev       (btn_prev),
        .btn_next       (btn_next),
        .btn_select     (btn_select),
        .btn_home       (btn_home),
        .app_exit       (app_exit),
        .cursor         (cursor),
        .disp_sel       (disp_sel),
        .app_run        (app_run),
        .frame_start    (frame_start),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always begin
        repeat (2) @(posedge clk);
        #2;
        framebufferClk = ~framebufferClk;
        if (framebufferClk) fb_edges++;
    end

    always @(posedge clk) begin
        #1;
        if ({cursor, disp_sel, app_run} !== mon_last) begin
            mon_last = {cursor, disp_sel, app_run};
            obs_q.push_back(mon_last);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_btn(input int id, input logic v);
        case (id)
            0: btn_prev   = v;
            1: btn_next   = v;
            2: btn_select = v;
            default: btn_home = v;
        endcase
    endtask

    task automatic pulse_btn(input int id, input int cycles);
        set_btn(id, 1'b1);
        repeat (cycles) @(negedge clk);
        set_btn(id, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_obs(output bit got);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (obs_q.size() > 0) begin
                got = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_fs(output bit got);
        got = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (frame_start === 1'b1) begin
                got = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_reset(output int base);
        @(negedge clk);
        while (framebufferClk) @(negedge clk);
        base    = fb_edges;
        reset_n = 1'b1;
    endtask

    task automatic score(input string name);
        bit got;
        logic [4:0] e, o;
        wait_obs(got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: no output change seen, expected %b", name, exp_q[0]);
            return;
        end
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
            n_fail++;
            $display("FAIL %s: got {cursor,disp_sel,app_run}=%b expected %b", name, o, e);
        end
    endtask

    task automatic test_reset();
        int base;
        bit got;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cursor, disp_sel, app_run, busy, frame_start} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 0000000",
                     {cursor, disp_sel, app_run, busy, frame_start});
        end
        release_reset(base);
        for (int k = 1; k <= 3; k++) begin
            wait_fs(got);
            n_checks++;
            if (!got || (fb_edges - base) !== k * c_PPF) begin
                n_fail++;
                $display("FAIL frame_period: frame %0d seen=%0d after %0d edges expected %0d",
                         k, got, fb_edges - base, k * c_PPF);
            end
            @(negedge clk);
            n_checks++;
            if (frame_start !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_width: got %b expected 0", frame_start);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || disp_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b disp_sel=%0d expected 0 0", busy, disp_sel);
        end
    endtask

    task automatic test_navigation();
        exp_q.push_back({1'b1, 2'd0, 2'd0});
        btn_next = 1'b1;
        repeat (10) @(negedge clk);
        btn_next = 1'b0;
        score("next_hold");
        repeat (12) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL next_once: got %0d extra changes expected 0", obs_q.size());
            obs_q.delete();
        end
        exp_q.push_back({1'b0, 2'd0, 2'd0});
        pulse_btn(1, 6);
        score("next_wrap");
        exp_q.push_back({1'b1, 2'd0, 2'd0});
        pulse_btn(0, 6);
        score("prev_wrap");
        pulse_btn(1, 3);
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0 || cursor !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch: cursor=%b changes=%0d expected 1 0", cursor, obs_q.size());
            obs_q.delete();
        end
        btn_prev = 1'b1;
        btn_next = 1'b1;
        repeat (6) @(negedge clk);
        btn_prev = 1'b0;
        btn_next = 1'b0;
        repeat (18) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0 || cursor !== 1'b1) begin
            n_fail++;
            $display("FAIL prev_next_both: cursor=%b changes=%0d expected 1 0", cursor, obs_q.size());
            obs_q.delete();
        end
    endtask

    // Presses select, waits for the launch boundary and checks outputs around it
    task automatic launch(input logic [1:0] exp_sel, input logic [1:0] exp_run, input string name);
        bit got;
        bit bad = 1'b0;
        bit seen_busy = 1'b0;
        exp_q.push_back({cursor, exp_sel, exp_run});
        btn_select = 1'b1;
        for (int i = 0; i < 20 && !seen_busy; i++) begin
            @(negedge clk);
            seen_busy = (busy === 1'b1);
        end
        btn_select = 1'b0;
        n_checks++;
        if (!seen_busy) begin
            n_fail++;
            $display("FAIL %s_busy: got busy=%b expected 1", name, busy);
        end
        for (int i = 0; i < 150 && frame_start !== 1'b1; i++) begin
            if (disp_sel !== 2'd0 || busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (bad || frame_start !== 1'b1 || disp_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL %s_pending: disp_sel=%0d frame_start=%b expected 0 1", name, disp_sel, frame_start);
        end
        @(negedge clk);
        n_checks++;
        if (disp_sel !== exp_sel || app_run !== exp_run || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_run: got disp_sel=%0d app_run=%b busy=%b expected %0d %b 0",
                     name, disp_sel, app_run, busy, exp_sel, exp_run);
        end
        score(name);
    endtask

    task automatic test_launch();
        bit got;
        wait_fs(got);
        repeat (20) @(negedge clk);
        launch(2'd2, 2'b10, "launch_breakout");
    endtask

    task automatic test_exit_app();
        bit got;
        repeat (10) @(negedge clk);
        exp_q.push_back({1'b1, 2'd0, 2'd0});
        app_exit = 1'b1;
        @(negedge clk);
        app_exit = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || disp_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL exit_busy: busy=%b disp_sel=%0d expected 1 2", busy, disp_sel);
        end
        wait_fs(got);
        n_checks++;
        if (!got || disp_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL exit_hold: frame=%0d disp_sel=%0d expected 1 2", got, disp_sel);
        end
        @(negedge clk);
        n_checks++;
        if (disp_sel !== 2'd0 || app_run !== 2'b00 || busy !== 1'b0 || cursor !== 1'b1) begin
            n_fail++;
            $display("FAIL exit_home: disp_sel=%0d app_run=%b busy=%b cursor=%b expected 0 00 0 1",
                     disp_sel, app_run, busy, cursor);
        end
        score("exit_app");
        exp_q.push_back({1'b0, 2'd0, 2'd0});
        pulse_btn(1, 6);
        score("home_nav_after_exit");
    endtask

    task automatic test_home_exit();
        bit got;
        bit seen_busy = 1'b0;
        launch(2'd1, 2'b01, "launch_gif");
        pulse_btn(1, 6);
        pulse_btn(2, 6);
        repeat (70) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0 || disp_sel !== 2'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL run_ignore: changes=%0d disp_sel=%0d busy=%b expected 0 1 0",
                     obs_q.size(), disp_sel, busy);
            obs_q.delete();
        end
        exp_q.push_back({1'b0, 2'd0, 2'd0});
        btn_home = 1'b1;
        for (int i = 0; i < 20 && !seen_busy; i++) begin
            @(negedge clk);
            seen_busy = (busy === 1'b1);
        end
        btn_home = 1'b0;
        n_checks++;
        if (!seen_busy || disp_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL home_busy: busy=%b disp_sel=%0d expected 1 1", busy, disp_sel);
        end
        wait_fs(got);
        @(negedge clk);
        n_checks++;
        if (!got || disp_sel !== 2'd0 || app_run !== 2'b00 || cursor !== 1'b0) begin
            n_fail++;
            $display("FAIL home_exit: disp_sel=%0d app_run=%b cursor=%b expected 0 00 0",
                     disp_sel, app_run, cursor);
        end
        score("home_exit");
    endtask

    task automatic test_async_reset();
        bit got;
        int e0;
        int base;
        launch(2'd1, 2'b01, "relaunch_gif");
        wait_fs(got);
        e0 = fb_edges;
        for (int i = 0; i < 100 && fb_edges != e0 + 7; i++) @(negedge clk);
        @(negedge clk);
        #2;
        exp_q.push_back({1'b0, 2'd0, 2'd0});
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (disp_sel !== 2'd0 || app_run !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: disp_sel=%0d app_run=%b busy=%b expected 0 00 0",
                     disp_sel, app_run, busy);
        end
        repeat (3) @(negedge clk);
        release_reset(base);
        wait_fs(got);
        n_checks++;
        if (!got || (fb_edges - base) !== c_PPF) begin
            n_fail++;
            $display("FAIL frame_restart: seen=%0d edges=%0d expected %0d", got, fb_edges - base, c_PPF);
        end
        score("async_reset_outputs");
        exp_q.push_back({1'b1, 2'd0, 2'd0});
        pulse_btn(1, 6);
        score("home_after_reset");
    endtask

    initial begin
        test_reset();
        test_navigation();
        test_launch();
        test_exit_app();
        test_home_exit();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/app_launcher_ctrl.md
Name: app_launcher_ctrl

Overview:
Home-screen controller that sequences which renderer drives the TFT pixel mux: home screen, GIF app or Breakout app. It debounces the navigation buttons, moves the icon highlight cursor, launches and exits apps, and gates each app's run enable. Display-source switches happen only on frame boundaries, which it derives by counting framebufferClk pixel strobes. It sits between the button synchronizers and the renderer pixel mux / app reset logic in the top level.

Parameters:
NUM_APPS, 2, number of launchable apps; index 0 = GIF, 1 = BREAKOUT.
PIX_PER_FRAME, 76800, framebufferClk rising edges per frame (240x320).
DEBOUNCE_CYCLES, 250000, consecutive clk cycles a raw button level must differ from its filtered level before the filtered level changes.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
framebufferClk  in  1  pixel strobe from tft_ili9341; sampled in the clk domain.
btn_prev  in  1  raw button, active-high, already synchronized to clk.
btn_next  in  1  raw button, active-high, already synchronized.
btn_select  in  1  raw button, active-high, already synchronized.
btn_home  in  1  raw button, active-high, already synchronized.
app_exit  in  1  level/pulse from the running app requesting return to home.
cursor  out  1  highlighted icon index (0 GIF, 1 BREAKOUT) for home_renderer.
disp_sel  out  2  pixel mux select: 0 home, 1 GIF, 2 Breakout.
app_run  out  NUM_APPS  one-hot run enable; an app is held in reset while its bit is 0.
frame_start  out  1  one-clk pulse at each frame boundary.
busy  out  1  high while a launch or exit is pending.

Behaviour:
- Reset (async, immediate, including mid-run): cursor=0, disp_sel=0, app_run=0, frame_start=0, busy=0, state=HOME, pixel counter=0, debounce counters and filtered levels=0, fbclk delay reg=0.
- Frame tracking: fbclk_d registers framebufferClk. A rising edge is framebufferClk=1 and fbclk_d=0. On each edge pix_cnt increments, wrapping PIX_PER_FRAME-1 -> 0. frame_start=1 for exactly the clk cycle after the edge that wraps pix_cnt.
- Debounce, per button: counter counts while raw != filtered and is cleared when they match. When the count reaches DEBOUNCE_CYCLES, filtered takes the raw value and the counter clears. A press event is a one-clk pulse on filtered 0->1. Holding a button produces exactly one event, and releasing produces none.
- FSM states: HOME, LAUNCH, RUN, EXIT.
- HOME:
  - next event: cursor = cursor+1, wrapping NUM_APPS-1 -> 0.
  - prev event: cursor = cursor-1, wrapping 0 -> NUM_APPS-1.
  - prev and next in the same cycle: both ignored.
  - select event: target <= cursor, go to LAUNCH. Select takes priority over a coincident prev/next, and cursor is unchanged.
  - home event and app_exit: ignored.
- LAUNCH: busy=1, all button events ignored. On the cycle frame_start=1, register disp_sel <= target+1 and app_run <= one-hot(target), and go to RUN; the new outputs are visible the next cycle. A frame_start coincident with the select in HOME does not count; the launch waits for the next boundary.
- RUN: busy=0. A home event or app_exit=1 sends the FSM to EXIT, with home and exit equivalent if they coincide. prev/next/select are ignored here (the apps consume the raw buttons themselves).
- EXIT: busy=1. On frame_start: disp_sel <= 0, app_run <= 0, go to HOME. cursor keeps the index of the exited app. A frame_start in the same cycle as entering EXIT does not count.
- disp_sel and app_run change only on frame_start cycles, never mid-frame (reset excepted).

Test Plan:
(Overrides for all scenarios: DEBOUNCE_CYCLES=4, PIX_PER_FRAME=16; framebufferClk toggles every 2 clk.)
1. Reset: release reset_n -> cursor=0, disp_sel=0, app_run=2'b00, busy=0; first frame_start after 16 strobe edges, width 1 clk, repeating every 16 edges.
2. Navigation: hold btn_next 10 clk -> cursor 0->1 exactly once; press next again -> cursor 0 (wrap); press prev -> cursor 1; 3-clk glitch on btn_next -> cursor unchanged; prev and next pressed together -> unchanged.
3. Launch: cursor=1, press select mid-frame -> busy=1, disp_sel stays 0 until the next frame_start; the cycle after that pulse disp_sel=2, app_run=2'b10, busy=0.
4. Exit via app_exit: in RUN, pulse app_exit 1 clk -> busy=1; after the next frame_start disp_sel=0, app_run=0, state HOME, cursor=1.
5. Exit via home and ignore rules: launch GIF (disp_sel=1, app_run=2'b01); btn_next/btn_select presses in RUN -> no change; btn_home press -> after the next frame_start disp_sel=0, cursor=0.
6. Async reset mid-RUN: assert reset_n low at pix_cnt=7 -> disp_sel=0, app_run=0, busy=0 immediately (no clk edge required); after release the frame count restarts from 0.
